// File: rtl/psum_accum_pack_if.sv
// psum_accum_pack_if: write-port sample bus in, packed int8 result bus out
interface psum_accum_pack_if #(parameter int IN_W = 22);
  logic                   we;
  logic [5:0]             waddr;
  logic                   first_pass;
  logic                   last_pass;
  logic signed [IN_W-1:0] wdata1, wdata2, wdata3, wdata4, wdata5, wdata6, wdata7, wdata8;
  logic                   done;
  logic [63:0]            dout;
  logic [5:0]             dout_addr;
  logic                   busy;
  modport master (
    output we, waddr, first_pass, last_pass,
    output wdata1, wdata2, wdata3, wdata4, wdata5, wdata6, wdata7, wdata8,
    input  done, dout, dout_addr, busy
  );
  modport slave (
    input  we, waddr, first_pass, last_pass,
    input  wdata1, wdata2, wdata3, wdata4, wdata5, wdata6, wdata7, wdata8,
    output done, dout, dout_addr, busy
  );
endinterface

// File: rtl/psum_accum_pack.sv
// psum_accum_pack: 8-lane partial-sum accumulator with saturating int8 requantise and pack
module psum_accum_pack #(
  parameter int DEPTH = 64,
  parameter int IN_W  = 22,
  parameter int ACC_W = 26,
  parameter int SHIFT = 9
) (
  input logic              clk,
  input logic              rst,
  psum_accum_pack_if.slave bus
);
  localparam logic signed [ACC_W:0] SMAX = (ACC_W+1)'(2**(ACC_W-1) - 1);
  localparam logic signed [ACC_W:0] SMIN = (ACC_W+1)'(-(2**(ACC_W-1)));
  logic signed [ACC_W-1:0] r_mem [DEPTH][8];
  logic                    r1_v, r1_first, r1_last, r2_v, r2_last, r3_v;
  logic [5:0]              r1_addr, r2_addr;
  logic signed [IN_W-1:0]  r1_wd [8];
  logic signed [ACC_W-1:0] r1_acc [8];
  logic signed [ACC_W-1:0] r2_sum [8];
  logic signed [IN_W-1:0]  w_in [8];
  logic signed [ACC_W:0]   w_raw [8];
  logic signed [ACC_W-1:0] w_sum [8];
  logic signed [ACC_W-1:0] w_rd [8];
  logic signed [ACC_W-1:0] w_q [8];
  logic [63:0]             w_pack;
  logic                    w_ok;
  assign w_ok     = bus.we && (int'(bus.waddr) < DEPTH);
  assign bus.busy = r1_v | r2_v | r3_v;
  always_comb begin
    w_in[0] = bus.wdata1;
    w_in[1] = bus.wdata2;
    w_in[2] = bus.wdata3;
    w_in[3] = bus.wdata4;
    w_in[4] = bus.wdata5;
    w_in[5] = bus.wdata6;
    w_in[6] = bus.wdata7;
    w_in[7] = bus.wdata8;
    w_pack  = '0;
    for (int i = 0; i < 8; i++) begin
      w_raw[i] = r1_first ? (ACC_W+1)'(r1_wd[i]) : (ACC_W+1)'(r1_acc[i]) + (ACC_W+1)'(r1_wd[i]);
      w_sum[i] = w_raw[i] > SMAX ? SMAX[ACC_W-1:0] : w_raw[i] < SMIN ? SMIN[ACC_W-1:0] : w_raw[i][ACC_W-1:0];
      // the sample in S1 writes this row on the same edge the new read is captured
      w_rd[i]  = (r1_v && r1_addr == bus.waddr) ? w_sum[i] : r_mem[bus.waddr][i];
      w_q[i]   = r2_sum[i] >>> SHIFT;
      w_pack[8*(7-i) +: 8] = w_q[i] > ACC_W'(127) ? 8'h7f : w_q[i] < ACC_W'(-128) ? 8'h80 : w_q[i][7:0];
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r1_v          <= 1'b0;
      r2_v          <= 1'b0;
      r3_v          <= 1'b0;
      bus.done      <= 1'b0;
      bus.dout      <= '0;
      bus.dout_addr <= '0;
    end else begin
      r1_v     <= w_ok;
      r2_v     <= r1_v;
      r3_v     <= r2_v;
      bus.done <= r2_v && r2_last;
      if (r2_v && r2_last) begin
        bus.dout      <= w_pack;
        bus.dout_addr <= r2_addr;
      end
    end
  always_ff @(posedge clk) begin
    r1_addr  <= bus.waddr;
    r1_first <= bus.first_pass;
    r1_last  <= bus.last_pass;
    r1_wd    <= w_in;
    r1_acc   <= w_rd;
    r2_addr  <= r1_addr;
    r2_last  <= r1_last;
    r2_sum   <= w_sum;
    if (r1_v) r_mem[r1_addr] <= w_sum;
  end
endmodule

// File: tb/tb_psum_accum_pack.sv
// tb_psum_accum_pack: directed and random stimulus against a sequential accumulate/quantise model
module tb_psum_accum_pack;
  localparam int DEPTH = 64;
  localparam longint AMAX = (64'sd1 <<< 25) - 1;
  localparam longint AMIN = -(64'sd1 <<< 25);
  typedef struct {
    bit v, d, hc;
    logic [63:0] dout, c;
    logic [5:0] addr;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  psum_accum_pack_if bus ();
  psum_accum_pack dut (.clk(clk), .rst(rst), .bus(bus));
  exp_t        q[$];
  longint      acc [DEPTH][8];
  bit          known [DEPTH];
  logic [63:0] last_dout;
  logic [5:0]  last_addr;
  int          ln [8];
  int          n_chk = 0;
  int          n_fail = 0;
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] quant(longint s);
    longint qv = s >>> 9;
    return qv > 127 ? 8'h7f : qv < -128 ? 8'h80 : 8'(qv);
  endfunction
  function automatic exp_t idle_e();
    exp_t e;
    e.v = 0; e.d = 0; e.hc = 0; e.dout = '0; e.c = '0; e.addr = '0;
    return e;
  endfunction
  task automatic set_all(int v);
    for (int l = 0; l < 8; l++) ln[l] = v;
  endtask
  task automatic step(bit we, int addr, bit first, bit last);
    exp_t        e;
    logic [63:0] pk = '0;
    longint      s;
    bit          busy_e = 0;
    bus.we = we; bus.waddr = 6'(addr); bus.first_pass = first; bus.last_pass = last;
    bus.wdata1 = 22'(ln[0]); bus.wdata2 = 22'(ln[1]); bus.wdata3 = 22'(ln[2]); bus.wdata4 = 22'(ln[3]);
    bus.wdata5 = 22'(ln[4]); bus.wdata6 = 22'(ln[5]); bus.wdata7 = 22'(ln[6]); bus.wdata8 = 22'(ln[7]);
    e = idle_e();
    e.v = we && addr < DEPTH;
    if (e.v) begin
      for (int l = 0; l < 8; l++) begin
        s = first ? longint'(ln[l]) : acc[addr][l] + longint'(ln[l]);
        s = s > AMAX ? AMAX : s < AMIN ? AMIN : s;
        acc[addr][l] = s;
        pk[8*(7-l) +: 8] = quant(s);
      end
      if (first) known[addr] = 1;
    end
    e.d = e.v && last;
    if (e.d) begin
      last_dout = pk;
      last_addr = 6'(addr);
    end
    e.dout = last_dout;
    e.addr = last_addr;
    q.push_back(e);
    @(posedge clk);
    #1;
    foreach (q[i]) busy_e |= q[i].v;
    chk("busy", 64'(bus.busy), 64'(busy_e));
    if (q.size() == 3) begin
      e = q.pop_front();
      chk("done", 64'(bus.done), 64'(e.d));
      chk("dout", bus.dout, e.dout);
      chk("dout_addr", 64'(bus.dout_addr), 64'(e.addr));
      if (e.hc) chk("dout_directed", bus.dout, e.c);
    end
  endtask
  task automatic expect_const(logic [63:0] c);
    q[q.size()-1].hc = 1;
    q[q.size()-1].c  = c;
  endtask
  task automatic idle(int n);
    set_all(0);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask
  task automatic enter_reset();
    rst = 1'b0;
    #2;
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_dout", bus.dout, 64'd0);
    chk("rst_addr", 64'(bus.dout_addr), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    q.delete();
    q.push_back(idle_e());
    q.push_back(idle_e());
    last_dout = '0;
    last_addr = '0;
    for (int a = 0; a < DEPTH; a++) known[a] = 0;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    bus.we = 0; bus.waddr = '0; bus.first_pass = 0; bus.last_pass = 0;
    bus.wdata1 = '0; bus.wdata2 = '0; bus.wdata3 = '0; bus.wdata4 = '0;
    bus.wdata5 = '0; bus.wdata6 = '0; bus.wdata7 = '0; bus.wdata8 = '0;
    #1;
    enter_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    set_all(512);
    step(1, 5, 1, 1);
    expect_const(64'h0101_0101_0101_0101);
    idle(3);
    set_all(0); ln[0] = 1024;
    step(1, 3, 1, 0);
    ln[0] = -3072;
    step(1, 3, 0, 1);
    expect_const(64'hfc00_0000_0000_0000);
    idle(3);
    set_all(0); ln[0] = 2**21 - 1; ln[7] = -(2**21);
    step(1, 20, 1, 1);
    expect_const(64'h7f00_0000_0000_0080);
    idle(3);
    set_all(0); ln[1] = 100;
    for (int i = 0; i < 4; i++) step(1, 7, i == 0, i == 3);
    expect_const(64'h0000_0000_0000_0000);
    idle(3);
    set_all(0); ln[1] = 1000;
    for (int i = 0; i < 4; i++) step(1, 7, i == 0, i == 3);
    expect_const(64'h0007_0000_0000_0000);
    idle(3);
    // drive the accumulator into both clamps over many passes
    for (int l = 0; l < 8; l++) ln[l] = l[0] ? -(2**21) : 2**21 - 1;
    for (int i = 0; i < 22; i++) step(1, 9, i == 0, i == 21);
    expect_const(64'h7f80_7f80_7f80_7f80);
    idle(3);
    for (int a = 0; a < 64; a++) begin
      for (int l = 0; l < 8; l++) ln[l] = int'($urandom_range(0, 4194303)) - 2097152;
      step(1, a, 1, 1);
    end
    idle(5);
    set_all(700);
    step(1, 10, 1, 1);
    step(1, 11, 1, 1);
    enter_reset();
    bus.we = 1; bus.waddr = 6'd12; bus.first_pass = 1; bus.last_pass = 1;
    @(posedge clk);
    #1;
    chk("rst_hold_done", 64'(bus.done), 64'd0);
    chk("rst_hold_busy", 64'(bus.busy), 64'd0);
    bus.we = 0;
    rst = 1'b1;
    idle(5);
    for (int i = 0; i < 400; i++) begin
      int  a;
      bit  we, first, last;
      a     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 7));
      we    = $urandom_range(0, 3) != 0;
      first = !known[a] || $urandom_range(0, 4) == 0;
      last  = $urandom_range(0, 2) == 0;
      for (int l = 0; l < 8; l++)
        ln[l] = $urandom_range(0, 1) ? int'($urandom_range(0, 4194303)) - 2097152
                                     : int'($urandom_range(0, 4000)) - 2000;
      step(we, a, first, last);
    end
    idle(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
